// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant/receive bundle of the tristate bus arbiter.
// The shared bus wire itself stays a plain inout on the arbiter.
interface tristate_bus_arbiter_if #(
   parameter int W = 8,
   parameter int M = 4
);
   logic [M-1:0]   req;
   logic [M*W-1:0] data_in;
   logic [M-1:0]   grant;
   logic           bus_busy;
   logic [W-1:0]   rx_data;
   logic [M-1:0]   rx_valid;

   modport master (
      output req,
      output data_in,
      input  grant,
      input  bus_busy,
      input  rx_data,
      input  rx_valid
   );

   modport slave (
      input  req,
      input  data_in,
      output grant,
      output bus_busy,
      output rx_data,
      output rx_valid
   );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of one shared tristate bus: burst-limited tenure,
// turnaround idle cycles between owners, registered receive path.
module tristate_bus_arbiter #(
   parameter int W         = 8,
   parameter int M         = 4,
   parameter int MAX_BURST = 4,
   parameter int TURN_CYC  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   tristate_bus_arbiter_if.slave bus,
   inout  wire [W-1:0]           bi_data
);
   localparam int IW = (M > 1) ? $clog2(M) : 1;
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
   localparam logic [IW-1:0] OWNER_LAST = IW'(M - 1);
   localparam logic [M-1:0]  ONE = {{(M-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_TURN
   } state_t;

   state_t        state;
   logic [M-1:0]  grant_q;
   logic [IW-1:0] owner;
   logic [IW-1:0] ptr;
   logic [BW-1:0] beat;
   logic [TW-1:0] turn;
   logic          busy_q;
   logic [W-1:0]  rx_data_q;
   logic [M-1:0]  rx_valid_q;

   logic          pick_vld;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] cand;
   logic          contended;
   logic          release_now;
   logic [IW-1:0] owner_nxt;
   logic [W-1:0]  tx;

   // Scan downward so the candidate closest to ptr is the last (winning) write.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = M - 1; k >= 0; k--) begin
         cand = IW'((int'(ptr) + k) % M);
         if (bus.req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign contended   = |(bus.req & ~grant_q);
   assign release_now = !bus.req[owner] || ((beat == BEAT_LAST) && contended);
   assign owner_nxt   = (owner == OWNER_LAST) ? '0 : owner + 1'b1;

   always_comb begin
      tx = '0;
      for (int i = 0; i < M; i++) begin
         if (grant_q[i]) tx = bus.data_in[i*W +: W];
      end
   end

   // Driven only from the registered grant, so two drivers can never overlap.
   assign bi_data = (|grant_q) ? tx : {W{1'bz}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         grant_q    <= '0;
         owner      <= '0;
         ptr        <= '0;
         beat       <= '0;
         turn       <= '0;
         busy_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= '0;
      end else begin
         rx_data_q  <= bi_data;
         rx_valid_q <= (|grant_q) ? ~grant_q : '0;
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  state   <= S_GRANT;
                  grant_q <= ONE << pick_idx;
                  owner   <= pick_idx;
                  beat    <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_GRANT: begin
               if (release_now) begin
                  grant_q <= '0;
                  ptr     <= owner_nxt;
                  if (TURN_CYC > 0) begin
                     state  <= S_TURN;
                     turn   <= '0;
                     busy_q <= 1'b1;
                  end else begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                  end
               end else if (beat != BEAT_LAST) begin
                  beat <= beat + 1'b1;
               end
            end
            S_TURN: begin
               if (turn == TURN_LAST) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  turn <= turn + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant    = grant_q;
   assign bus.bus_busy = busy_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
Clocked successor to the two-port tristate bus: M channels share one W-bit bidirectional wire.
- A round-robin arbiter grants exactly one driver at a time, so the bus never has two drivers.
- Bus tenure is limited to a burst length, with programmable bus-turnaround idle cycles between owners.
- Non-owning channels receive the bus value through a registered receive path.

Parameters:
W, 8, bus data width in bits (>=1)
M, 4, number of channels (>=2)
MAX_BURST, 4, max consecutive beats one owner may hold the bus while another channel is requesting (>=1)
TURN_CYC, 1, idle high-Z cycles inserted between owners (>=0)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  M  per-channel bus request, level-sensitive
data_in  input  M*W  per-channel transmit data; channel i occupies bits [i*W +: W]
grant  output  M  one-hot registered grant, all-zero when bus is not owned
bus_busy  output  1  high in GRANT and TURN states
bi_data  inout  W  shared bus, driven with data_in of granted channel, otherwise all-Z
rx_data  output  W  registered copy of bi_data
rx_valid  output  M  per-channel receive strobe, registered

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, grant=0, bus_busy=0, bi_data=all-Z, rx_data=0, rx_valid=0, rr pointer=0, beat counter=0, turn counter=0.
- Reset asserted mid-burst or mid-turnaround: on that edge, grant clears and the bus goes Z, with no turnaround.
- bi_data is purely combinational from registered grant: drives data_in[g] when grant bit g=1, else all-Z. It never drives when grant==0.
- States:
  - IDLE: bus Z.
    - If req!=0, select the first requesting channel searching upward from pointer ptr with wrap (ptr, ptr+1, ... M-1, 0, ...).
    - Set grant to that one-hot value on the next edge, beat=0, go to GRANT.
    - Latency req->grant is 1 cycle from IDLE.
  - GRANT, owner g: each cycle beat increments, saturating at MAX_BURST-1.
    - Release when req[g]=0, or when beat==MAX_BURST-1 and any other req bit is high.
    - On release: grant<=0, ptr<=(g+1) mod M. Go to TURN with turn=0 if TURN_CYC>0, else directly to IDLE.
    - With TURN_CYC=0, arbitration happens in IDLE on the next cycle, so there is always at least one Z cycle between owners.
    - If no other channel requests, the owner keeps the bus indefinitely while req[g]=1.
  - TURN: bus Z, bus_busy=1. turn increments; after TURN_CYC cycles in TURN, go to IDLE. Requests are ignored in TURN.
- Receive path:
  - Every cycle, rx_data<=bi_data, with Z/X bits passed through as sampled.
  - rx_valid<= ~grant when grant!=0, else 0. Every non-owner gets a strobe; the owner gets none.
  - rx_data and rx_valid lag the bus by 1 cycle.
- Simultaneous requests: resolved strictly by the round-robin order above, never by fixed priority.
- Request changes while in GRANT for non-owners only affect the burst-limit release condition.
- data_in changes during GRANT appear on bi_data in the same cycle, as a combinational path.

Test Plan:
1. W=8,M=4,MAX_BURST=4,TURN_CYC=1. Reset, then req=0001, data_in[0]=8'hA5 for 3 cycles, then drop req.
   -> grant=0001 one cycle after req. bi_data=A5 for 3 cycles. rx_valid=1110 and rx_data=A5 one cycle later. Then 1 cycle TURN with bi_data=ZZ, bus_busy=1, then IDLE.
2. req=0110 held together from IDLE, ptr=0.
   -> grant=0010 for 4 beats, release, 1 Z cycle, 1 IDLE cycle, then grant=0100 for 4 beats, then back to channel 1. grant is never 0110.
3. req=1000 alone held 10 cycles.
   -> grant=1000 continuously for 10 beats; burst limit does not apply with no contenders.
4. TURN_CYC=0, req=0011 held.
   -> owners alternate 0001/0010 every 4 beats, with exactly one Z cycle (grant=0) between them.
5. rst asserted on beat 2 of a channel-2 burst.
   -> on the next edge grant=0, bi_data=Z, rx_valid=0, rx_data=0, bus_busy=0, ptr=0. After rst drops with req=0100 held, grant=0100 after 1 cycle.
6. Every test, continuously: popcount(grant)<=1, and bi_data is Z whenever grant=0.
